// File: rtl/sram2k_pkg.sv
// sram2k_pkg -- shared constants and types for the 512x32 dual-port SRAM
// controller (sram2k_ctrl and its read-response pipeline).
//   ADDR_W / DATA_W / MASK_W : default word-address, data and byte-mask widths
//   DEPTH                    : number of SRAM words cleared after reset
//   state_t                  : controller FSM states
package sram2k_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int DEPTH  = 512;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/sram2k_rd_pipe.sv
// sram2k_rd_pipe -- fixed two-edge read-response pipeline for one SRAM port.
// A read accepted at edge E0 reaches the SRAM at E1; its dout is captured at
// E2, and rvalid/rdata are presented for the single cycle after E2.
//   clk, rst_n : clock, asynchronous active-low reset (flushes in-flight reads)
//   accept     : a read request is accepted at this edge
//   dout       : SRAM read data for this port
//   rvalid     : one-cycle read response strobe
//   rdata      : read response data (holds until the next response)
module sram2k_rd_pipe #(
  parameter int DATA_W = sram2k_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept,
  input  logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  // [0]: request is at the SRAM inputs, [1]: SRAM has sampled it
  logic [1:0] inflight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      rvalid   <= 1'b0;
      // NOTE: rdata is a single output register, so it gets a reset value;
      // the word storage itself lives in the SRAM macro and is never reset.
      rdata    <= '0;
    end else begin
      inflight <= {inflight[0], accept};
      rvalid   <= inflight[1];
      if (inflight[1]) begin
        rdata <= dout;
      end
    end
  end

endmodule

// File: rtl/sram2k_ctrl.sv
// sram2k_ctrl -- controller for a 512x32 SRAM with one read/write port (0)
// and one read-only port (1). After reset it optionally zero-fills the whole
// array, then serves port A (read/write) on SRAM port 0 and port B (read) on
// SRAM port 1, one request per port per cycle, fixed read latency.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   a_valid/a_ready            : port-A request handshake
//   a_we, a_wmask, a_addr,
//   a_wdata                    : port-A request (write=1), byte mask, address, data
//   a_rvalid/a_rdata           : port-A read response
//   b_valid/b_ready/b_addr     : port-B read request
//   b_rvalid/b_rdata           : port-B read response
//   init_done                  : array clear finished, requests are accepted
//   csb0, web0, wmask0, addr0,
//   din0 / dout0               : SRAM port 0 (1RW), registered outputs
//   csb1, addr1 / dout1        : SRAM port 1 (1R), registered outputs
module sram2k_ctrl
  import sram2k_pkg::MASK_W, sram2k_pkg::DEPTH, sram2k_pkg::state_t,
         sram2k_pkg::ST_INIT, sram2k_pkg::ST_RUN;
#(
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int ADDR_W         = sram2k_pkg::ADDR_W,
  parameter int DATA_W         = sram2k_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [MASK_W-1:0] a_wmask,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              init_done,
  output logic              csb0,
  output logic              web0,
  output logic [MASK_W-1:0] wmask0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] dout0,
  output logic              csb1,
  output logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] dout1
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_last;   // final clear word has been issued
  logic              collide;
  logic              a_acc;
  logic              b_acc;

  // A same-cycle write and read of one word on the two SRAM ports would race
  // inside the macro, so port B is held off for that cycle and retries.
  assign collide = a_valid && a_we && (a_addr == b_addr);

  // init_done is registered, so both readies are low in reset and in ST_INIT.
  assign a_ready = init_done;
  assign b_ready = init_done && !collide;
  assign a_acc   = a_valid && a_ready;
  assign b_acc   = b_valid && b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET) state <= ST_INIT;
      else                state <= ST_RUN;
      clr_addr  <= '0;
      clr_last  <= 1'b0;
      init_done <= 1'b0;
      csb0      <= 1'b1;
      web0      <= 1'b1;
      wmask0    <= '0;
      addr0     <= '0;
      din0      <= '0;
      csb1      <= 1'b1;
      addr1     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples pre-edge values and a later default-override wins cleanly.
      csb0 <= 1'b1;
      web0 <= 1'b1;
      csb1 <= 1'b1;
      case (state)
        ST_INIT: begin
          if (!clr_last) begin
            csb0   <= 1'b0;
            web0   <= 1'b0;
            wmask0 <= '1;
            addr0  <= clr_addr;
            din0   <= '0;
            // The counter parks on the last word instead of wrapping.
            if (clr_addr == LAST_ADDR) clr_last <= 1'b1;
            else                       clr_addr <= clr_addr + 1'b1;
          end else begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          init_done <= 1'b1;
          if (a_acc) begin
            csb0  <= 1'b0;
            web0  <= !a_we;
            addr0 <= a_addr;
            if (a_we) begin
              wmask0 <= a_wmask;
              din0   <= a_wdata;
            end else begin
              wmask0 <= '0;
            end
          end
          if (b_acc) begin
            csb1  <= 1'b0;
            addr1 <= b_addr;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Writes produce no response, so only port-A reads enter its pipeline.
  sram2k_rd_pipe #(.DATA_W(DATA_W)) u_pipe_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .accept (a_acc && !a_we),
    .dout   (dout0),
    .rvalid (a_rvalid),
    .rdata  (a_rdata)
  );

  sram2k_rd_pipe #(.DATA_W(DATA_W)) u_pipe_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .accept (b_acc),
    .dout   (dout1),
    .rvalid (b_rvalid),
    .rdata  (b_rdata)
  );

endmodule

// File: tb/tb_sram2k_ctrl.sv
// tb_sram2k_ctrl -- self-checking bench for sram2k_ctrl (CLEAR_ON_RESET=1).
// Contains a behavioural SRAM macro, a transaction-level reference model
// (word array + per-port response queues with due edges) and one negedge
// compare process, plus directed sequences with hand-computed literals.
module tb_sram2k_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_valid, a_we, a_ready, a_rvalid;
  logic [3:0]  a_wmask;
  logic [8:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_valid, b_ready, b_rvalid;
  logic [8:0]  b_addr;
  logic [31:0] b_rdata;
  logic        init_done;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [8:0]  addr0, addr1;
  logic [31:0] din0, dout0, dout1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram2k_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_wmask(a_wmask),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata), .init_done(init_done),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0), .csb1(csb1), .addr1(addr1), .dout1(dout1)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // ---------------- behavioural SRAM macro (clocked, 1RW + 1R) ----------------
  logic [31:0] sram [512];
  initial begin
    for (int i = 0; i < 512; i++) sram[i] = $urandom;
    dout0 = $urandom;
    dout1 = $urandom;
  end
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int i = 0; i < 4; i++) if (wmask0[i]) sram[addr0][8*i +: 8] <= din0[8*i +: 8];
      end else begin
        dout0 <= sram[addr0];
      end
    end
    if (!csb1) dout1 <= sram[addr1];
  end

  // ---------------- reference model ----------------
  typedef struct { int unsigned due; logic [31:0] data; } resp_t;
  resp_t       qa[$], qb[$];
  logic [31:0] mem_m [512];
  int unsigned edge_n = 0;
  int          rel = 0;       // edges since reset release
  bit          run = 0;       // requests may be accepted in the coming cycle
  bit          e_csb0 = 1, e_web0 = 1, e_csb1 = 1, e_chk_mask = 0, e_chk_din = 0;
  logic [3:0]  e_wmask;
  logic [8:0]  e_addr0 = '0, e_addr1 = '0;
  logic [31:0] e_din;
  bit          acc_a, acc_b;
  resp_t       r;

  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      qa.delete(); qb.delete();
      rel = 0; run = 0;
      e_csb0 = 1; e_web0 = 1; e_csb1 = 1; e_chk_mask = 0; e_chk_din = 0;
      e_addr0 = '0; e_addr1 = '0;
    end else begin
      rel++;
      acc_a = run && a_valid;
      acc_b = run && b_valid && !(a_valid && a_we && a_addr == b_addr);
      e_csb0 = 1; e_web0 = 1; e_csb1 = 1; e_chk_mask = 0; e_chk_din = 0;
      if (rel <= 512) begin            // clear: edge k writes zero to word k-1
        mem_m[rel-1] = '0;
        e_csb0 = 0; e_web0 = 0; e_wmask = 4'hF; e_din = '0;
        e_chk_mask = 1; e_chk_din = 1; e_addr0 = 9'(rel - 1);
      end
      if (acc_b) begin
        r.due = edge_n + 2; r.data = mem_m[b_addr]; qb.push_back(r);
        e_csb1 = 0; e_addr1 = b_addr;
      end
      if (acc_a) begin
        e_csb0 = 0; e_addr0 = a_addr; e_chk_mask = 1;
        if (a_we) begin
          e_web0 = 0; e_wmask = a_wmask; e_din = a_wdata; e_chk_din = 1;
          mem_m[a_addr] = merge(mem_m[a_addr], a_wdata, a_wmask);
        end else begin
          e_web0 = 1; e_wmask = 4'h0;
          r.due = edge_n + 2; r.data = mem_m[a_addr]; qa.push_back(r);
        end
      end
      run = (rel >= 513);
    end
  end

  // ---------------- compare process ----------------
  bit exp_av, exp_bv;
  always @(negedge clk) begin
    if (!rst_n || rel == 0) begin
      check("rst csb0", csb0, 1);       check("rst csb1", csb1, 1);
      check("rst web0", web0, 1);       check("rst wmask0", wmask0, 0);
      check("rst addr0", addr0, 0);     check("rst addr1", addr1, 0);
      check("rst din0", din0, 0);       check("rst init_done", init_done, 0);
      check("rst a_rvalid", a_rvalid, 0); check("rst b_rvalid", b_rvalid, 0);
      check("rst a_rdata", a_rdata, 0); check("rst b_rdata", b_rdata, 0);
      check("rst a_ready", a_ready, 0); check("rst b_ready", b_ready, 0);
    end else begin
      exp_av = (qa.size() != 0) && (qa[0].due == edge_n);
      exp_bv = (qb.size() != 0) && (qb[0].due == edge_n);
      check("a_rvalid", a_rvalid, exp_av);
      if (exp_av) begin check("a_rdata", a_rdata, qa[0].data); void'(qa.pop_front()); end
      check("b_rvalid", b_rvalid, exp_bv);
      if (exp_bv) begin check("b_rdata", b_rdata, qb[0].data); void'(qb.pop_front()); end
      check("init_done", init_done, run);
      check("a_ready", a_ready, run);
      check("b_ready", b_ready, run && !(a_valid && a_we && a_addr == b_addr));
      check("csb0", csb0, e_csb0);
      check("web0", web0, e_web0);
      check("addr0", addr0, e_addr0);
      if (e_chk_mask) check("wmask0", wmask0, e_wmask);
      if (e_chk_din)  check("din0", din0, e_din);
      check("csb1", csb1, e_csb1);
      check("addr1", addr1, e_addr1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic a_write(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] m);
    a_valid = 1; a_we = 1; a_addr = addr; a_wdata = data; a_wmask = m;
    cyc_n(1);
    a_valid = 0; a_we = 0;
  endtask

  task automatic a_read_expect(input string nm, input logic [8:0] addr, input logic [31:0] exp);
    a_valid = 1; a_we = 0; a_addr = addr;
    cyc_n(1);                                   // accepted at E0
    a_valid = 0;
    check({nm, " rvalid after E0"}, a_rvalid, 0);
    cyc_n(1);
    check({nm, " rvalid after E1"}, a_rvalid, 0);
    cyc_n(1);
    check({nm, " rvalid after E2"}, a_rvalid, 1);
    check({nm, " rdata"}, a_rdata, exp);
    cyc_n(1);
    check({nm, " rvalid one cycle"}, a_rvalid, 0);
  endtask

  task automatic finish_sim;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  initial begin
    #400000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    a_valid = 0; a_we = 0; a_wmask = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_addr = 0;
    #1 rst_n = 0;
    cyc_n(3);
    rst_n = 1;

    // Reset mid-clear at word 200: clear must restart from word 0.
    repeat (201) @(posedge clk);
    #2;
    check("mid-clear addr0", addr0, 200);
    check("mid-clear csb0", csb0, 0);
    rst_n = 0;
    #1;
    check("async rst addr0", addr0, 0);
    check("async rst csb0", csb0, 1);
    cyc_n(2);
    rst_n = 1;
    cyc_n(1);
    check("restart addr0", addr0, 0);
    check("restart csb0", csb0, 0);
    check("restart wmask0", wmask0, 4'hF);
    repeat (511) @(posedge clk);
    #2;
    check("edge512 addr0", addr0, 511);
    check("edge512 init_done", init_done, 0);
    cyc_n(1);
    check("edge513 init_done", init_done, 1);
    check("edge513 csb0", csb0, 1);
    check("edge513 a_ready", a_ready, 1);

    // Cleared contents at the array boundaries and middle.
    a_read_expect("clr0", 9'd0, 32'h0);
    a_read_expect("clr255", 9'd255, 32'h0);
    a_read_expect("clr511", 9'd511, 32'h0);

    // Full write, then partial-mask overwrite.
    a_write(9'h05, 32'hDEADBEEF, 4'hF);
    a_read_expect("full wr", 9'h05, 32'hDEADBEEF);
    a_write(9'h05, 32'h11223344, 4'b0101);
    a_read_expect("mask wr", 9'h05, 32'hDE22BE44);

    // Same-cycle write/read collision on 0x10: B stalls, retry sees new data.
    a_valid = 1; a_we = 1; a_addr = 9'h10; a_wdata = 32'hCAFEF00D; a_wmask = 4'hF;
    b_valid = 1; b_addr = 9'h10;
    #1;
    check("collide b_ready", b_ready, 0);
    check("collide a_ready", a_ready, 1);
    cyc_n(1);
    a_valid = 0; a_we = 0;
    #1;
    check("retry b_ready", b_ready, 1);
    cyc_n(1);
    b_valid = 0;
    cyc_n(2);
    check("retry b_rvalid", b_rvalid, 1);
    check("retry b_rdata", b_rdata, 32'hCAFEF00D);
    cyc_n(1);

    // Back-to-back port-B reads of 0..7: eight gapless, ordered pulses.
    for (int i = 0; i < 8; i++) a_write(9'(i), 32'h100 + i, 4'hF);
    b_valid = 1; b_addr = 9'd0;
    for (int k = 0; k < 10; k++) begin
      cyc_n(1);
      if (k + 1 < 8) b_addr = 9'(k + 1);
      else           b_valid = 0;
      if (k >= 2) begin
        check("b2b b_rvalid", b_rvalid, 1);
        check("b2b b_rdata", b_rdata, 32'h100 + k - 2);
      end
    end
    cyc_n(1);
    check("b2b trailing b_rvalid", b_rvalid, 0);

    // Randomized traffic over a small address window to provoke collisions.
    for (int c = 0; c < 3000; c++) begin
      a_valid = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
      a_addr  = 9'($urandom_range(0, 15)); a_wdata = $urandom;
      a_wmask = 4'($urandom_range(0, 15));
      b_valid = 1'($urandom_range(0, 1)); b_addr = 9'($urandom_range(0, 15));
      if (c % 500 == 499) begin a_addr = 9'($urandom_range(0, 511)); b_addr = a_addr; end
      cyc_n(1);
    end
    a_valid = 0; b_valid = 0;
    cyc_n(4);

    // Reset with reads in flight on both ports: no response may escape.
    a_valid = 1; a_we = 0; a_addr = 9'h03; b_valid = 1; b_addr = 9'h04;
    cyc_n(1);
    a_valid = 0; b_valid = 0;
    cyc_n(1);
    rst_n = 0;
    #1;
    check("flush a_rvalid", a_rvalid, 0);
    check("flush b_rvalid", b_rvalid, 0);
    for (int k = 0; k < 4; k++) begin
      cyc_n(1);
      check("flush hold a_rvalid", a_rvalid, 0);
      check("flush hold b_rvalid", b_rvalid, 0);
    end
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      cyc_n(1);
      check("post-flush a_rvalid", a_rvalid, 0);
      check("post-flush b_rvalid", b_rvalid, 0);
      check("post-flush clear addr0", addr0, 9'(k));
    end
    repeat (510) @(posedge clk);
    #2;
    check("reinit init_done", init_done, 1);
    a_read_expect("reinit5", 9'h05, 32'h0);

    for (int c = 0; c < 200; c++) begin
      a_valid = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
      a_addr  = 9'($urandom_range(0, 7)); a_wdata = $urandom;
      a_wmask = 4'($urandom_range(0, 15));
      b_valid = 1'($urandom_range(0, 1)); b_addr = 9'($urandom_range(0, 7));
      cyc_n(1);
    end
    a_valid = 0; b_valid = 0;
    cyc_n(4);
    check("qa drained", qa.size(), 0);
    check("qb drained", qb.size(), 0);
    finish_sim();
  end

endmodule
